// File: rtl/tree_walker.sv
`default_nettype none
// ============================================================================
// Module   : tree_walker
// Purpose  : Walks one decision tree held in an external node ROM for a
//            feature vector and returns the leaf class over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module tree_walker #(
    parameter int NODE_WIDTH   = 120,
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_FEATURES = 16,
    parameter int FEAT_WIDTH   = 64,
    parameter int MAX_DEPTH    = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_FEATURES*FEAT_WIDTH-1:0] features,
    output logic [ADDR_WIDTH-1:0]            rom_addr,
    input  logic [NODE_WIDTH-1:0]            node_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [3:0]                       out_class,
    output logic                             out_err,
    output logic [5:0]                       out_depth
);

    localparam logic [3:0] c_type_leaf = 4'h3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                            state_q, state_d;
    logic [NUM_FEATURES*FEAT_WIDTH-1:0] feat_q, feat_d;
    logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
    logic [5:0]                        depth_q, depth_d;
    logic [3:0]                        class_q, class_d;
    logic                              err_q, err_d;

    logic [11:0]           w_id;
    logic [3:0]            w_type;
    logic [FEAT_WIDTH-1:0] w_thr;
    logic [11:0]           w_left;
    logic [11:0]           w_right;
    logic [FEAT_WIDTH-1:0] w_feat;
    logic                  w_go_left;
    logic                  w_unused;

    assign w_id    = node_data[107:96];
    assign w_type  = node_data[95:92];
    assign w_thr   = node_data[91:28];
    assign w_left  = node_data[27:16];
    assign w_right = node_data[15:4];

    assign w_unused = ^{node_data[NODE_WIDTH-1:108], w_id[11:ADDR_WIDTH],
                        w_left[11:ADDR_WIDTH], w_right[11:ADDR_WIDTH]};

    // Maps a double onto an unsigned key whose order matches numeric order;
    // -0 is folded onto +0 so the two compare equal.
    function automatic logic [FEAT_WIDTH-1:0] f_key(input logic [FEAT_WIDTH-1:0] x);
        logic [FEAT_WIDTH-1:0] v;
        v = (x[FEAT_WIDTH-2:0] == '0) ? '0 : x;
        f_key = v[FEAT_WIDTH-1] ? ~v : {1'b1, v[FEAT_WIDTH-2:0]};
    endfunction

    always_comb begin
        w_feat = '0;
        for (int k = 0; k < NUM_FEATURES; k++) begin
            if (w_type == 4'(k)) begin
                w_feat = feat_q[k*FEAT_WIDTH +: FEAT_WIDTH];
            end
        end
    end

    assign w_go_left = (f_key(w_feat) <= f_key(w_thr));

    always_comb begin
        state_d = state_q;
        feat_d  = feat_q;
        addr_d  = addr_q;
        depth_d = depth_q;
        class_d = class_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    feat_d  = features;
                    addr_d  = '0;
                    depth_d = '0;
                    class_d = '0;
                    err_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: state_d = S_EVAL;
            S_EVAL: begin
                state_d = S_DONE;
                if (w_id[ADDR_WIDTH-1:0] != addr_q) begin
                    err_d = 1'b1;
                end else if (w_type == c_type_leaf) begin
                    class_d = node_data[3:0];
                end else if (32'(w_type) >= 32'(NUM_FEATURES)) begin
                    err_d = 1'b1;
                end else if (depth_q == 6'(MAX_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    addr_d  = w_go_left ? w_left[ADDR_WIDTH-1:0] : w_right[ADDR_WIDTH-1:0];
                    depth_d = depth_q + 6'd1;
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            feat_q  <= '0;
            addr_q  <= '0;
            depth_q <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            feat_q  <= feat_d;
            addr_q  <= addr_d;
            depth_q <= depth_d;
            class_q <= class_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign rom_addr  = addr_q;
    assign out_class = class_q;
    assign out_err   = err_q;
    assign out_depth = depth_q;

endmodule
`default_nettype wire

// File: tb/tb_tree_walker.sv
`default_nettype none
// ============================================================================
// Module   : tb_tree_walker
// Purpose  : Scoreboard bench for tree_walker with a real-valued tree model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tree_walker;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1023:0] features = '0;
    logic [9:0]    rom_addr;
    logic [119:0]  node_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_class;
    logic          out_err;
    logic [5:0]    out_depth;

    tree_walker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .features  (features),
        .rom_addr  (rom_addr),
        .node_data (node_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .out_depth (out_depth)
    );

    always #5 clk = ~clk;

    logic [119:0] rom [0:1023];
    always @(posedge clk) node_data <= rom[rom_addr];

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int checks;
    int passes;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [3:0] cls;
        logic       err;
        int         depth;
        int         acc;
        int         lat;
    } exp_t;
    exp_t sb_q[$];

    // Reference: follow the tree with real-number comparisons.
    function automatic void model(input logic [1023:0] f, output logic [3:0] cls,
                                  output logic err, output int depth);
        int a;
        int t;
        logic [119:0] n;
        a = 0; depth = 0; cls = '0; err = 1'b0;
        for (int it = 0; it < 100; it++) begin
            n = rom[a];
            t = int'(n[95:92]);
            if (int'(n[105:96]) != a) begin err = 1'b1; return; end
            if (t == 3) begin cls = n[3:0]; return; end
            if (t >= 16 || depth == 32) begin err = 1'b1; return; end
            if ($bitstoreal(f[t*64 +: 64]) <= $bitstoreal(n[91:28])) a = int'(n[25:16]);
            else a = int'(n[13:4]);
            depth++;
        end
    endfunction

    function automatic logic [119:0] mk_node(input logic [11:0] id, input logic [3:0] typ,
                                             input logic [63:0] thr, input logic [11:0] l,
                                             input logic [11:0] r, input logic [3:0] cls);
        return {12'($urandom), id, typ, thr, l, r, cls};
    endfunction

    function automatic logic [63:0] rnd_dbl();
        case ($urandom_range(0, 9))
            0:       return 64'h8000000000000000;
            1:       return 64'h0;
            default: return $realtobits(($itor($urandom_range(0, 64)) - 32.0) * 0.25);
        endcase
    endfunction

    // 0 = random ready, 1 = hold low, 2 = hold high
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    logic       hold = 1'b0;
    logic [3:0] h_cls;
    logic       h_err;
    logic [5:0] h_dep;
    exp_t       m_e;
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else if (out_valid) begin
            if (!hold) begin
                hold  = 1'b1;
                h_cls = out_class;
                h_err = out_err;
                h_dep = out_depth;
                chk("result_expected", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    m_e = sb_q[0];
                    chk("class", 64'(out_class), 64'(m_e.cls));
                    chk("err", 64'(out_err), 64'(m_e.err));
                    chk("depth", 64'(out_depth), 64'(m_e.depth));
                    chk("latency", 64'(cyc - m_e.acc), 64'(m_e.lat));
                end
            end else begin
                chk("hold_stable", 64'({out_class, out_err, out_depth}), 64'({h_cls, h_err, h_dep}));
            end
            if (out_ready) begin
                hold = 1'b0;
                if (sb_q.size() > 0) void'(sb_q.pop_front());
            end
        end
    end

    int addr_log[$];

    task automatic send(input logic [1023:0] f, input bit push);
        exp_t e;
        bit   ok;
        @(negedge clk);
        features = f;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 64'(in_ready), 64'd1);
        if (push) begin
            model(f, e.cls, e.err, e.depth);
            e.acc = cyc;
            e.lat = 2 * e.depth + 3;
            sb_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        addr_log.delete();
        for (int t = 0; t < 400; t++) begin
            if (addr_log.size() == 0 || addr_log[$] != int'(rom_addr)) addr_log.push_back(int'(rom_addr));
            if (sb_q.size() == 0) return;
            @(negedge clk);
        end
        chk("result_timeout", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic run(input logic [1023:0] f);
        send(f, 1'b1);
        wait_done();
    endtask

    task automatic chk_path(input string name, input int second);
        chk(name, 64'({addr_log.size(), addr_log.size() > 0 ? addr_log[0] : -1,
                       addr_log.size() > 1 ? addr_log[1] : -1}),
            64'({2, 0, second}));
    endtask

    logic [1023:0] fv;
    logic [11:0]   nid;
    logic [3:0]    ntyp;

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_outputs", 64'({out_class, out_err, out_depth}), 64'd0);
        rst = 1'b0;

        // Root leaf
        rom[0] = mk_node(12'h000, 4'h3, 64'h0, 12'h0, 12'h0, 4'h1);
        run('0);

        // Tie and exceed on feature 1 against 192.5
        rom[0] = mk_node(12'h000, 4'h1, 64'h4068100000000000, 12'h001, 12'h002, 4'h0);
        rom[1] = mk_node(12'h001, 4'h3, 64'h0, 12'h0, 12'h0, 4'h0);
        rom[2] = mk_node(12'h802, 4'h3, 64'h0, 12'h0, 12'h0, 4'h1);
        fv = '0; fv[64 +: 64] = 64'h4068100000000000;
        run(fv);
        chk_path("path_tie", 1);
        fv[64 +: 64] = 64'h4068180000000000;
        run(fv);
        chk_path("path_exceed", 2);

        // Negative and signed-zero compares on feature 0
        rom[0] = mk_node(12'h000, 4'h0, 64'hC000000000000000, 12'h401, 12'hC02, 4'h0);
        rom[1] = mk_node(12'h001, 4'h3, 64'h0, 12'h0, 12'h0, 4'h2);
        rom[2] = mk_node(12'h002, 4'h3, 64'h0, 12'h0, 12'h0, 4'h5);
        fv = '0; fv[63:0] = 64'hC008000000000000;
        run(fv);
        chk_path("path_neg3", 1);
        fv[63:0] = 64'hBFF0000000000000;
        run(fv);
        chk_path("path_neg1", 2);
        rom[0] = mk_node(12'h000, 4'h0, 64'h0, 12'h001, 12'h002, 4'h0);
        fv[63:0] = 64'h8000000000000000;
        run(fv);
        chk_path("path_negzero", 1);

        // Depth guard: node 0 loops onto itself
        rom[0] = mk_node(12'h000, 4'h0, 64'h0, 12'hC00, 12'h400, 4'h0);
        run('0);
        // Id mismatch at the root
        rom[0] = mk_node(12'h005, 4'h3, 64'h0, 12'h0, 12'h0, 4'h9);
        run('0);

        // Backpressure
        rom[0] = mk_node(12'h000, 4'h3, 64'h0, 12'h0, 12'h0, 4'hA);
        rdy_mode = 1;
        @(negedge clk);
        send('0, 1'b1);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            in_valid = 1'b1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
        chk("bp_no_extra", 64'(sb_q.size()), 64'd0);
        rdy_mode = 0;

        // Reset during the second WAIT
        rom[0] = mk_node(12'h000, 4'h0, 64'h0, 12'h001, 12'h001, 4'h0);
        rom[1] = mk_node(12'h001, 4'h3, 64'h0, 12'h0, 12'h0, 4'h7);
        send('0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        chk("midrst_rom_addr", 64'(rom_addr), 64'd0);
        run('0);

        // Random trees and vectors
        for (int tr = 0; tr < 40; tr++) begin
            for (int i = 0; i < 16; i++) begin
                nid = ($urandom_range(0, 29) == 0) ? 12'($urandom_range(0, 15)) : 12'(i);
                nid[11:10] = 2'($urandom);
                if ($urandom_range(0, 9) < 4) ntyp = 4'h3;
                else begin
                    ntyp = 4'($urandom_range(0, 14));
                    if (ntyp >= 4'h3) ntyp = ntyp + 4'h1;
                end
                rom[i] = mk_node(nid, ntyp, rnd_dbl(),
                                 {2'($urandom), 10'($urandom_range(0, 15))},
                                 {2'($urandom), 10'($urandom_range(0, 15))},
                                 4'($urandom));
            end
            for (int v = 0; v < 4; v++) begin
                for (int k = 0; k < 16; k++) fv[k*64 +: 64] = rnd_dbl();
                run(fv);
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", passes, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
